// File: rtl/y86_pkg.sv
// Shared y86 definitions: condition-function codes, CC bit layout, reset value
// and the state encoding of the condition-query handshake.
package y86_pkg;

  // jXX / cmovXX function codes
  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  // Bit positions inside the {ZF,SF,OF} condition-code word
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  // Flags after reset: zero result, positive, no overflow
  localparam logic [2:0] CC_RST = 3'b100;

  // Query handshake states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    RESP = 2'd2
  } cc_state_e;

endpackage

// File: rtl/cc_unit_cond_eval.sv
// Pure combinational condition evaluator. Maps a {ZF,SF,OF} word and an ifun
// code onto the branch/move decision; unknown codes yield cnd=0 with err set.
// Kept standalone so the fetch-stage branch predictor can reuse it.
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd,
  output logic       err
);

  logic zf;
  logic sf;
  logic of;
  logic lt;

  assign zf = cc[CC_ZF];
  assign sf = cc[CC_SF];
  assign of = cc[CC_OF];
  assign lt = sf ^ of;

  // Decode the requested condition against the supplied flags
  always_comb begin
    cnd = 1'b0;
    err = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = lt | zf;
      C_L:     cnd = lt;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~lt;
      C_G:     cnd = ~lt & ~zf;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/cc_unit.sv
// Condition-code register and condition-query unit for the y86 execute stage.
// Flags come from the ALU result; queries are answered one cycle later with a
// registered cnd, and a query that arrives during a stall is parked in PEND
// until the pipeline moves again.
module cc_unit
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_of,
  input  logic             set_cc,
  input  logic             cc_squash,
  input  logic             stall,
  input  logic             cond_req,
  input  logic [3:0]       ifun,
  output logic             cnd,
  output logic             cnd_valid,
  output logic             cnd_err,
  output logic [2:0]       cc_out
);

  logic [2:0] cc_q;
  logic [2:0] cc_d;
  logic       cc_we;
  logic [2:0] new_flags;

  cc_state_e  state_q;
  cc_state_e  state_d;
  logic [3:0] ifun_q;
  logic [3:0] ifun_d;
  logic       cnd_q;
  logic       cnd_d;
  logic       err_q;
  logic       err_d;

  logic [3:0] eval_ifun;
  logic       eval_cnd;
  logic       eval_err;

  assign alu_ready = ~stall;

  assign new_flags[CC_ZF] = (alu_result == '0);
  assign new_flags[CC_SF] = alu_result[WIDTH-1];
  assign new_flags[CC_OF] = alu_of;

  assign cc_we = alu_valid & alu_ready & set_cc & ~cc_squash;
  assign cc_d  = cc_we ? new_flags : cc_q;

  // A parked query uses its latched code; otherwise the live ifun is evaluated
  assign eval_ifun = (state_q == PEND) ? ifun_q : ifun;

  // Evaluation always sees the flags held before this edge's update
  cond_eval u_cond_eval (
    .cc   (cc_q),
    .ifun (eval_ifun),
    .cnd  (eval_cnd),
    .err  (eval_err)
  );

  // Next-state and response capture for the query handshake
  always_comb begin
    state_d = state_q;
    ifun_d  = ifun_q;
    cnd_d   = cnd_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (cond_req && !stall) begin
          state_d = RESP;
          cnd_d   = eval_cnd;
          err_d   = eval_err;
        end else if (cond_req && stall) begin
          state_d = PEND;
          ifun_d  = ifun;
        end else begin
          state_d = IDLE;
        end
      end
      PEND: begin
        if (!stall) begin
          state_d = RESP;
          cnd_d   = eval_cnd;
          err_d   = eval_err;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched query and registered flags; reset drops any pending query
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ifun_q  <= C_YES;
      cnd_q   <= 1'b0;
      err_q   <= 1'b0;
      cc_q    <= CC_RST;
    end else begin
      state_q <= state_d;
      ifun_q  <= ifun_d;
      cnd_q   <= cnd_d;
      err_q   <= err_d;
      cc_q    <= cc_d;
    end
  end

  assign cnd_valid = (state_q == RESP);
  assign cnd_err   = cnd_valid & err_q;
  assign cnd       = cnd_q;
  assign cc_out    = cc_q;

endmodule

// File: tb/tb_cc_unit.sv
// Directed bench for cc_unit: flag updates from ALU results, squash/stall
// gating, signed conditions, parked queries, the same-edge hazard, invalid
// codes, back-to-back queries and reset while a query is pending.
module tb_cc_unit;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [63:0] alu_result;
  logic        alu_of;
  logic        set_cc;
  logic        cc_squash;
  logic        stall;
  logic        cond_req;
  logic [3:0]  ifun;
  logic        cnd;
  logic        cnd_valid;
  logic        cnd_err;
  logic [2:0]  cc_out;

  int total;
  int bad;

  cc_unit #(.WIDTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_result (alu_result),
    .alu_of     (alu_of),
    .set_cc     (set_cc),
    .cc_squash  (cc_squash),
    .stall      (stall),
    .cond_req   (cond_req),
    .ifun       (ifun),
    .cnd        (cnd),
    .cnd_valid  (cnd_valid),
    .cnd_err    (cnd_err),
    .cc_out     (cc_out)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] res, input logic of,
                               input logic sc, input logic sq, input logic st,
                               input logic req, input logic [3:0] fn);
    alu_valid  = v;
    alu_result = res;
    alu_of     = of;
    set_cc     = sc;
    cc_squash  = sq;
    stall      = st;
    cond_req   = req;
    ifun       = fn;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Linear directed sequence; inputs change 1 ns after each rising edge
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    alu_valid = 0; alu_result = '0; alu_of = 0; set_cc = 0;
    cc_squash = 0; stall = 0; cond_req = 0; ifun = 4'd0;
    tick();
    tick();
    checkOutput("rst_cc",    8'(cc_out),    8'h4);
    checkOutput("rst_valid", 8'(cnd_valid), 8'h0);
    checkOutput("rst_cnd",   8'(cnd),       8'h0);
    checkOutput("rst_err",   8'(cnd_err),   8'h0);
    rst = 1'b0;

    // query e after reset: ZF=1
    applyStimulus(0, 64'd0, 0, 0, 0, 0, 1, 4'd3);
    checkOutput("e_rst_valid", 8'(cnd_valid), 8'h1);
    checkOutput("e_rst_cnd",   8'(cnd),       8'h1);
    applyStimulus(0, 64'd0, 0, 0, 0, 0, 0, 4'd0);
    checkOutput("e_rst_drop",  8'(cnd_valid), 8'h0);
    checkOutput("cnd_hold",    8'(cnd),       8'h1);

    // flag updates from AND results
    applyStimulus(1, 64'd1, 0, 1, 0, 0, 0, 4'd0);
    checkOutput("cc_one",  8'(cc_out), 8'h0);
    applyStimulus(1, 64'h7FFF_FFFF_FFFF_FFFF & 64'h8000_0000_0000_0000, 0, 1, 0, 0, 0, 4'd0);
    checkOutput("cc_zero", 8'(cc_out), 8'h4);
    applyStimulus(1, 64'h8000_0000_0000_0000, 0, 1, 0, 0, 0, 4'd0);
    checkOutput("cc_neg",  8'(cc_out), 8'h2);

    // signed conditions with SF=1, OF=0, back to back
    applyStimulus(0, 64'd0, 0, 0, 0, 0, 1, 4'd2);
    checkOutput("l_valid", 8'(cnd_valid), 8'h1);
    checkOutput("l_cnd",   8'(cnd), 8'h1);
    applyStimulus(0, 64'd0, 0, 0, 0, 0, 1, 4'd5);
    checkOutput("ge_cnd",  8'(cnd), 8'h0);
    applyStimulus(0, 64'd0, 0, 0, 0, 0, 1, 4'd6);
    checkOutput("g_cnd",   8'(cnd), 8'h0);
    applyStimulus(0, 64'd0, 0, 0, 0, 0, 1, 4'd1);
    checkOutput("le_cnd",  8'(cnd), 8'h1);
    checkOutput("le_valid", 8'(cnd_valid), 8'h1);
    applyStimulus(0, 64'd0, 0, 0, 0, 0, 0, 4'd0);
    checkOutput("sign_idle", 8'(cnd_valid), 8'h0);

    // squash and stall both block the update
    applyStimulus(1, 64'd0, 0, 1, 1, 0, 0, 4'd0);
    checkOutput("squash_cc", 8'(cc_out), 8'h2);
    applyStimulus(1, 64'd0, 0, 1, 0, 1, 0, 4'd0);
    checkOutput("stall_cc",    8'(cc_out),    8'h2);
    checkOutput("stall_ready", 8'(alu_ready), 8'h0);

    // query parked for 3 stalled cycles; later ifun must be ignored
    applyStimulus(0, 64'd0, 0, 0, 0, 1, 1, 4'd3);
    checkOutput("pend1_valid", 8'(cnd_valid), 8'h0);
    applyStimulus(0, 64'd0, 0, 0, 0, 1, 1, 4'd0);
    checkOutput("pend2_valid", 8'(cnd_valid), 8'h0);
    applyStimulus(0, 64'd0, 0, 0, 0, 1, 1, 4'd0);
    checkOutput("pend3_valid", 8'(cnd_valid), 8'h0);
    applyStimulus(0, 64'd0, 0, 0, 0, 0, 0, 4'd0);
    checkOutput("pend_resp_valid", 8'(cnd_valid), 8'h1);
    checkOutput("pend_resp_cnd",   8'(cnd),       8'h0);
    applyStimulus(0, 64'd0, 0, 0, 0, 0, 0, 4'd0);
    checkOutput("pend_done", 8'(cnd_valid), 8'h0);

    // same-edge update and query: query sees old flags
    applyStimulus(1, 64'd0, 0, 1, 0, 0, 0, 4'd0);
    checkOutput("hz_pre_cc", 8'(cc_out), 8'h4);
    applyStimulus(1, 64'd1, 0, 1, 0, 0, 1, 4'd3);
    checkOutput("hz_cnd_old", 8'(cnd),    8'h1);
    checkOutput("hz_cc_new",  8'(cc_out), 8'h0);
    applyStimulus(0, 64'd0, 0, 0, 0, 0, 1, 4'd3);
    checkOutput("hz_cnd_new", 8'(cnd), 8'h0);
    applyStimulus(0, 64'd0, 0, 0, 0, 0, 0, 4'd0);

    // invalid function code
    applyStimulus(0, 64'd0, 0, 0, 0, 0, 1, 4'd9);
    checkOutput("inv_valid", 8'(cnd_valid), 8'h1);
    checkOutput("inv_cnd",   8'(cnd),       8'h0);
    checkOutput("inv_err",   8'(cnd_err),   8'h1);
    applyStimulus(0, 64'd0, 0, 0, 0, 0, 0, 4'd0);
    checkOutput("inv_err_clr", 8'(cnd_err), 8'h0);

    // back-to-back always then ne (ZF=0)
    applyStimulus(0, 64'd0, 0, 0, 0, 0, 1, 4'd0);
    checkOutput("b2b0_valid", 8'(cnd_valid), 8'h1);
    checkOutput("b2b0_cnd",   8'(cnd),       8'h1);
    applyStimulus(0, 64'd0, 0, 0, 0, 0, 1, 4'd4);
    checkOutput("b2b1_valid", 8'(cnd_valid), 8'h1);
    checkOutput("b2b1_cnd",   8'(cnd),       8'h1);
    checkOutput("b2b1_err",   8'(cnd_err),   8'h0);
    applyStimulus(0, 64'd0, 0, 0, 0, 0, 0, 4'd0);
    checkOutput("b2b_end", 8'(cnd_valid), 8'h0);

    // reset while a query is parked: no response afterwards
    applyStimulus(0, 64'd0, 0, 0, 0, 1, 1, 4'd0);
    rst = 1'b1;
    applyStimulus(0, 64'd0, 0, 0, 0, 0, 0, 4'd0);
    checkOutput("rpend_valid", 8'(cnd_valid), 8'h0);
    checkOutput("rpend_cc",    8'(cc_out),    8'h4);
    checkOutput("rpend_cnd",   8'(cnd),       8'h0);
    rst = 1'b0;
    applyStimulus(0, 64'd0, 0, 0, 0, 0, 0, 4'd0);
    checkOutput("rpend_after", 8'(cnd_valid), 8'h0);

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
